// File: rtl/cmd_rsp_seq_pkg.sv
// Shared SD host definitions: response type encoding, sequencer states, counter width.
`default_nettype none
package cmd_rsp_seq_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    RSP_NONE = 2'b00,
    RSP_R136 = 2'b01,
    RSP_R48  = 2'b10,
    RSP_R48B = 2'b11
  } rsp_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_SENT,
    ST_GAP,
    ST_LISTEN,
    ST_RECEIVE,
    ST_BUSY_WAIT,
    ST_DONE
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/cmd_rsp_seq_counter.sv
// Generic saturating up-counter with synchronous clear, gated by a clock strobe.
`default_nettype none
module cmd_rsp_seq_counter
  import cmd_rsp_seq_pkg::*;
#(
  parameter int WIDTH = CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_o <= '0;
    end else if (en_i) begin
      if (clr_i) begin
        count_o <= '0;
      end else if (inc_i && (count_o != {WIDTH{1'b1}})) begin
        count_o <= count_o + WIDTH'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cmd_rsp_seq.sv
// SD command/response sequencer: issues a command, waits for the response
// (or busy release on DAT0) and reports completion and error status.
`default_nettype none
module cmd_rsp_seq
  import cmd_rsp_seq_pkg::*;
#(
  parameter int NcrCycles   = 64,
  parameter int BusyCycles  = 65535,
  parameter int ListenDelay = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clk_en_i,
  input  logic         cmd_req_i,
  input  logic [5:0]   cmd_index_i,
  input  logic [31:0]  cmd_arg_i,
  input  logic [1:0]   rsp_type_i,
  input  logic         crc_chk_en_i,
  input  logic         idx_chk_en_i,
  output logic         cmd_gnt_o,
  output logic         cmd_start_o,
  output logic [5:0]   cmd_index_o,
  output logic [31:0]  cmd_arg_o,
  input  logic         cmd_done_i,
  output logic         start_listening_o,
  output logic         long_rsp_o,
  output logic         rsp_abort_o,
  input  logic         receiving_i,
  input  logic         rsp_valid_i,
  input  logic         end_bit_err_i,
  input  logic         crc_corr_i,
  input  logic [119:0] rsp_i,
  input  logic         dat0_i,
  output logic [119:0] rsp_o,
  output logic         cmd_inhibit_o,
  output logic         cmd_complete_o,
  output logic         trans_complete_o,
  output logic         timeout_err_o,
  output logic         crc_err_o,
  output logic         end_bit_err_o,
  output logic         index_err_o,
  output logic         busy_timeout_err_o
);

  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(ListenDelay - 1);
  localparam logic [CNT_W-1:0] NCR_LAST  = CNT_W'(NcrCycles - 1);
  localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BusyCycles - 1);

  seq_state_e       state;
  rsp_type_e        rsp_type_q;
  logic             crc_en_q;
  logic             idx_en_q;
  logic [CNT_W-1:0] cnt;

  logic gap_done;
  logic listen_expired;
  logic busy_expired;
  logic cnt_inc;
  logic cnt_clr;
  logic rx_crc_err;
  logic rx_idx_err;
  logic rx_any_err;

  assign gap_done       = (cnt >= GAP_LAST);
  assign listen_expired = (cnt >= NCR_LAST);
  assign busy_expired   = (cnt >= BUSY_LAST);

  // The shared counter only runs in the three waiting states and sits at
  // zero everywhere else, so each waiting state starts from a clean count.
  assign cnt_inc = (state == ST_GAP) || (state == ST_LISTEN) || (state == ST_BUSY_WAIT);
  assign cnt_clr = !cnt_inc || ((state == ST_GAP) && gap_done);

  assign rx_crc_err = crc_en_q & ~crc_corr_i;
  assign rx_idx_err = idx_en_q && (rsp_type_q != RSP_R136) && (rsp_i[37:32] != cmd_index_o);
  assign rx_any_err = rx_crc_err | end_bit_err_i | rx_idx_err;

  assign cmd_inhibit_o = (state != ST_IDLE);

  cmd_rsp_seq_counter #(
    .WIDTH(CNT_W)
  ) u_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (clk_en_i),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .count_o(cnt)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state              <= ST_IDLE;
      rsp_type_q         <= RSP_NONE;
      crc_en_q           <= 1'b0;
      idx_en_q           <= 1'b0;
      cmd_index_o        <= '0;
      cmd_arg_o          <= '0;
      cmd_gnt_o          <= 1'b0;
      cmd_start_o        <= 1'b0;
      start_listening_o  <= 1'b0;
      long_rsp_o         <= 1'b0;
      rsp_abort_o        <= 1'b0;
      cmd_complete_o     <= 1'b0;
      trans_complete_o   <= 1'b0;
      rsp_o              <= '0;
      timeout_err_o      <= 1'b0;
      crc_err_o          <= 1'b0;
      end_bit_err_o      <= 1'b0;
      index_err_o        <= 1'b0;
      busy_timeout_err_o <= 1'b0;
    end else if (clk_en_i) begin
      cmd_gnt_o         <= 1'b0;
      cmd_start_o       <= 1'b0;
      start_listening_o <= 1'b0;
      rsp_abort_o       <= 1'b0;
      cmd_complete_o    <= 1'b0;
      trans_complete_o  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_req_i) begin
            cmd_index_o        <= cmd_index_i;
            cmd_arg_o          <= cmd_arg_i;
            rsp_type_q         <= rsp_type_e'(rsp_type_i);
            crc_en_q           <= crc_chk_en_i;
            idx_en_q           <= idx_chk_en_i;
            cmd_gnt_o          <= 1'b1;
            rsp_o              <= '0;
            timeout_err_o      <= 1'b0;
            crc_err_o          <= 1'b0;
            end_bit_err_o      <= 1'b0;
            index_err_o        <= 1'b0;
            busy_timeout_err_o <= 1'b0;
            state              <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cmd_start_o <= 1'b1;
          state       <= ST_WAIT_SENT;
        end
        ST_WAIT_SENT: begin
          if (cmd_done_i) begin
            if (rsp_type_q == RSP_NONE) begin
              state <= ST_DONE;
            end else begin
              long_rsp_o <= (rsp_type_q == RSP_R136);
              state      <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gap_done) begin
            start_listening_o <= 1'b1;
            state             <= ST_LISTEN;
          end
        end
        ST_LISTEN: begin
          // A start bit on the last allowed strobe still counts as a response.
          if (receiving_i) begin
            state <= ST_RECEIVE;
          end else if (listen_expired) begin
            timeout_err_o <= 1'b1;
            rsp_abort_o   <= 1'b1;
            long_rsp_o    <= 1'b0;
            state         <= ST_DONE;
          end
        end
        ST_RECEIVE: begin
          if (rsp_valid_i) begin
            rsp_o         <= rsp_i;
            crc_err_o     <= rx_crc_err;
            end_bit_err_o <= end_bit_err_i;
            index_err_o   <= rx_idx_err;
            long_rsp_o    <= 1'b0;
            if ((rsp_type_q == RSP_R48B) && !rx_any_err) begin
              state <= ST_BUSY_WAIT;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_BUSY_WAIT: begin
          if (dat0_i) begin
            trans_complete_o <= 1'b1;
            state            <= ST_DONE;
          end else if (busy_expired) begin
            busy_timeout_err_o <= 1'b1;
            state              <= ST_DONE;
          end
        end
        ST_DONE: begin
          cmd_complete_o <= 1'b1;
          state          <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cmd_rsp_seq.sv
// Bench for cmd_rsp_seq: per-strobe expected-output timeline built from transaction descriptions.
`default_nettype none
module tb_cmd_rsp_seq;
  import cmd_rsp_seq_pkg::*;

  localparam int NCR = 64;
  localparam int LD  = 2;
  localparam int NA  = 2048;

  logic clk_i = 1'b0;
  logic rst_i, clk_en_i, cmd_req_i, crc_chk_en_i, idx_chk_en_i, cmd_done_i;
  logic receiving_i, rsp_valid_i, end_bit_err_i, crc_corr_i, dat0_i;
  logic [5:0] cmd_index_i;
  logic [31:0] cmd_arg_i;
  logic [1:0] rsp_type_i;
  logic [119:0] rsp_i;

  logic cmd_gnt_o, cmd_start_o, start_listening_o, long_rsp_o, rsp_abort_o;
  logic cmd_inhibit_o, cmd_complete_o, trans_complete_o;
  logic timeout_err_o, crc_err_o, end_bit_err_o, index_err_o, busy_timeout_err_o;
  logic [5:0] cmd_index_o;
  logic [31:0] cmd_arg_o;
  logic [119:0] rsp_o;

  logic b_gnt, b_start, b_listen, b_long, b_abort, b_inhibit, b_complete, b_trans;
  logic b_to, b_crc, b_eb, b_ix, b_bto;
  logic [5:0] b_index;
  logic [31:0] b_arg;
  logic [119:0] b_rsp;

  always #5 clk_i = ~clk_i;

  cmd_rsp_seq dut (
    .clk_i(clk_i), .rst_i(rst_i), .clk_en_i(clk_en_i), .cmd_req_i(cmd_req_i),
    .cmd_index_i(cmd_index_i), .cmd_arg_i(cmd_arg_i), .rsp_type_i(rsp_type_i),
    .crc_chk_en_i(crc_chk_en_i), .idx_chk_en_i(idx_chk_en_i), .cmd_gnt_o(cmd_gnt_o),
    .cmd_start_o(cmd_start_o), .cmd_index_o(cmd_index_o), .cmd_arg_o(cmd_arg_o),
    .cmd_done_i(cmd_done_i), .start_listening_o(start_listening_o), .long_rsp_o(long_rsp_o),
    .rsp_abort_o(rsp_abort_o), .receiving_i(receiving_i), .rsp_valid_i(rsp_valid_i),
    .end_bit_err_i(end_bit_err_i), .crc_corr_i(crc_corr_i), .rsp_i(rsp_i), .dat0_i(dat0_i),
    .rsp_o(rsp_o), .cmd_inhibit_o(cmd_inhibit_o), .cmd_complete_o(cmd_complete_o),
    .trans_complete_o(trans_complete_o), .timeout_err_o(timeout_err_o), .crc_err_o(crc_err_o),
    .end_bit_err_o(end_bit_err_o), .index_err_o(index_err_o),
    .busy_timeout_err_o(busy_timeout_err_o)
  );

  // Short busy limit instance, fed the same stimulus.
  cmd_rsp_seq #(.BusyCycles(50)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .clk_en_i(clk_en_i), .cmd_req_i(cmd_req_i),
    .cmd_index_i(cmd_index_i), .cmd_arg_i(cmd_arg_i), .rsp_type_i(rsp_type_i),
    .crc_chk_en_i(crc_chk_en_i), .idx_chk_en_i(idx_chk_en_i), .cmd_gnt_o(b_gnt),
    .cmd_start_o(b_start), .cmd_index_o(b_index), .cmd_arg_o(b_arg),
    .cmd_done_i(cmd_done_i), .start_listening_o(b_listen), .long_rsp_o(b_long),
    .rsp_abort_o(b_abort), .receiving_i(receiving_i), .rsp_valid_i(rsp_valid_i),
    .end_bit_err_i(end_bit_err_i), .crc_corr_i(crc_corr_i), .rsp_i(rsp_i), .dat0_i(dat0_i),
    .rsp_o(b_rsp), .cmd_inhibit_o(b_inhibit), .cmd_complete_o(b_complete),
    .trans_complete_o(b_trans), .timeout_err_o(b_to), .crc_err_o(b_crc),
    .end_bit_err_o(b_eb), .index_err_o(b_ix), .busy_timeout_err_o(b_bto)
  );

  typedef struct packed {
    logic gnt, start, listen, lng, abort, inh, cmpl, trans;
    logic to, crc, eb, ix, bto, chk_cmd;
    logic [5:0] idx;
    logic [31:0] arg;
    logic [119:0] rsp;
  } exp_t;

  typedef struct packed {
    logic req, done, recv, valid, dat0;
  } in_t;

  exp_t ex[NA];
  in_t  stim[NA];

  int sn = 0;
  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;
  int listen_sn = -1, abort_sn = -1, trans_sn = -1, cmpl_sn = -1;
  bit b_trans_seen = 1'b0;
  bit strobe_seen;
  exp_t cur;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at strobe %0d: got %0h expected %0h", name, sn, act, req);
    end
  endtask

  function automatic logic [119:0] mk_rsp(input logic [5:0] idx, input logic [31:0] s);
    return {24'hC0FFEE, 32'hDEADBEEF, 26'd0, idx, 32'hCAFE0000 | s};
  endfunction

  // Single compare process: every clock, outputs must match the timeline entry of the last strobe.
  always @(posedge clk_i) begin
    strobe_seen = clk_en_i && !rst_i;
    if (strobe_seen) sn++;
    #1;
    if (chk_on && !rst_i) begin
      cur = ex[sn];
      chk("cmd_gnt", cmd_gnt_o, cur.gnt);
      chk("cmd_start", cmd_start_o, cur.start);
      chk("start_listening", start_listening_o, cur.listen);
      chk("long_rsp", long_rsp_o, cur.lng);
      chk("rsp_abort", rsp_abort_o, cur.abort);
      chk("cmd_inhibit", cmd_inhibit_o, cur.inh);
      chk("cmd_complete", cmd_complete_o, cur.cmpl);
      chk("trans_complete", trans_complete_o, cur.trans);
      chk("timeout_err", timeout_err_o, cur.to);
      chk("crc_err", crc_err_o, cur.crc);
      chk("end_bit_err", end_bit_err_o, cur.eb);
      chk("index_err", index_err_o, cur.ix);
      chk("busy_timeout_err", busy_timeout_err_o, cur.bto);
      chk("rsp_o", rsp_o, cur.rsp);
      if (cur.chk_cmd) begin
        chk("cmd_index_o", cmd_index_o, cur.idx);
        chk("cmd_arg_o", cmd_arg_o, cur.arg);
      end
    end
    if (strobe_seen) begin
      if (start_listening_o) listen_sn = sn;
      if (rsp_abort_o) abort_sn = sn;
      if (trans_complete_o) trans_sn = sn;
      if (cmd_complete_o) cmpl_sn = sn;
      if (b_trans) b_trans_seen = 1'b1;
    end
  end

  task automatic clear_from(input int n);
    for (int i = n; i < NA; i++) begin
      ex[i] = '0;
      stim[i] = '0;
      stim[i].dat0 = 1'b1;
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    clk_en_i = 1'b0;
    @(negedge clk_i);
    cmd_req_i   = stim[sn+1].req;
    cmd_done_i  = stim[sn+1].done;
    receiving_i = stim[sn+1].recv;
    rsp_valid_i = stim[sn+1].valid;
    dat0_i      = stim[sn+1].dat0;
    clk_en_i    = 1'b1;
    @(posedge clk_i);
    #2;
  endtask

  task automatic run_to(input int t);
    while (sn < t) tick();
  endtask

  // Builds the expected per-strobe timeline of one transaction starting at the next strobe.
  // d: strobes from start pulse to cmd_done; r: LISTEN strobe of the start bit (0 = none);
  // vd: RECEIVE strobes until rsp_valid; b: BUSY_WAIT strobe where DAT0 rises.
  task automatic plan(input rsp_type_e t, input logic [5:0] idx, input logic [31:0] arg,
                      input bit crc_en, input bit idx_en, input int d, input int r, input int vd,
                      input logic [119:0] rsp, input bit corr, input bit eb, input int b,
                      output int l0, output int v, output int e);
    int g, w, ds, rx;
    bit ce, ie;
    g = sn + 1;
    cmd_index_i = idx; cmd_arg_i = arg; rsp_type_i = t;
    crc_chk_en_i = crc_en; idx_chk_en_i = idx_en;
    rsp_i = rsp; crc_corr_i = corr; end_bit_err_i = eb;
    clear_from(g);
    for (int i = g; i <= g + 3; i++) stim[i].req = 1'b1;
    ex[g].gnt = 1'b1;
    ex[g+1].start = 1'b1;
    w = g + 1 + d;
    stim[w].done = 1'b1;
    l0 = 0; v = 0;
    if (t == RSP_NONE) begin
      ds = w;
    end else begin
      l0 = w + LD;
      ex[l0].listen = 1'b1;
      if (r > 0 && r <= NCR) begin
        rx = l0 + r;
        stim[rx].recv = 1'b1;
        v = rx + vd;
        stim[v].valid = 1'b1;
        for (int i = w; i < v; i++) ex[i].lng = (t == RSP_R136);
        ce = crc_en & ~corr;
        ie = idx_en && (t != RSP_R136) && (rsp[37:32] != idx);
        for (int i = v; i < NA; i++) begin
          ex[i].rsp = rsp; ex[i].crc = ce; ex[i].eb = eb; ex[i].ix = ie;
        end
        ds = v;
        if (t == RSP_R48B && !(ce | eb | ie)) begin
          for (int j = 1; j < b; j++) stim[v+j].dat0 = 1'b0;
          ds = v + b;
          ex[ds].trans = 1'b1;
        end
      end else begin
        ds = l0 + NCR;
        ex[ds].abort = 1'b1;
        for (int i = w; i < ds; i++) ex[i].lng = (t == RSP_R136);
        for (int i = ds; i < NA; i++) ex[i].to = 1'b1;
      end
    end
    for (int i = g; i <= ds; i++) begin
      ex[i].inh = 1'b1; ex[i].chk_cmd = 1'b1; ex[i].idx = idx; ex[i].arg = arg;
    end
    ex[ds+1].cmpl = 1'b1;
    e = ds + 1;
  endtask

  initial begin
    int l0, v, e;
    rst_i = 1'b1; clk_en_i = 1'b0; cmd_req_i = 1'b0; cmd_done_i = 1'b0;
    receiving_i = 1'b0; rsp_valid_i = 1'b0; dat0_i = 1'b1;
    cmd_index_i = '0; cmd_arg_i = '0; rsp_type_i = '0; crc_chk_en_i = 1'b0;
    idx_chk_en_i = 1'b0; end_bit_err_i = 1'b0; crc_corr_i = 1'b1; rsp_i = '0;
    clear_from(0);
    repeat (3) @(negedge clk_i);
    chk("reset_inhibit", cmd_inhibit_o, 1'b0);
    chk("reset_rsp", rsp_o, 120'd0);
    chk("reset_complete", cmd_complete_o, 1'b0);
    rst_i = 1'b0;
    chk_on = 1'b1;
    run_to(3);

    // R48 CMD17, clean response
    plan(RSP_R48, 6'd17, 32'h1000, 1'b1, 1'b1, 3, 5, 2, mk_rsp(6'd17, 32'd1), 1'b1, 1'b0, 0, l0, v, e);
    run_to(e);
    chk("t1_rsp_literal", rsp_o, 120'hC0FFEE_DEADBEEF_00000011_CAFE0001);
    chk("t1_complete_strobe", cmpl_sn, 18);
    chk("t1_index_err", index_err_o, 1'b0);

    // R48 with response index 16 against command 17
    plan(RSP_R48, 6'd17, 32'h1000, 1'b1, 1'b1, 2, 3, 1, mk_rsp(6'd16, 32'd2), 1'b1, 1'b0, 0, l0, v, e);
    run_to(e);
    chk("t2_index_err", index_err_o, 1'b1);
    chk("t2_complete_strobe", cmpl_sn, e);

    // R136 CMD2: index check suppressed, CRC failure reported
    plan(RSP_R136, 6'd2, 32'h0, 1'b1, 1'b1, 2, 4, 3, mk_rsp(6'd63, 32'd3), 1'b0, 1'b0, 0, l0, v, e);
    run_to(e);
    chk("t3_crc_err", crc_err_o, 1'b1);
    chk("t3_index_err", index_err_o, 1'b0);

    // No start bit: timeout after 64 strobes
    plan(RSP_R48, 6'd13, 32'h55AA, 1'b1, 1'b1, 2, 0, 1, mk_rsp(6'd13, 32'd4), 1'b1, 1'b0, 0, l0, v, e);
    run_to(e);
    chk("t4_timeout_err", timeout_err_o, 1'b1);
    chk("t4_abort_distance", abort_sn - listen_sn, 64);

    // Start bit on the 64th strobe: reception wins
    plan(RSP_R48, 6'd13, 32'h55AA, 1'b1, 1'b1, 2, 64, 1, mk_rsp(6'd13, 32'd5), 1'b1, 1'b0, 0, l0, v, e);
    run_to(e);
    chk("t5_timeout_err", timeout_err_o, 1'b0);
    chk("t5_rsp_literal", rsp_o, 120'hC0FFEE_DEADBEEF_0000000D_CAFE0005);

    // No-response command
    plan(RSP_NONE, 6'd0, 32'h0, 1'b0, 1'b0, 2, 0, 1, '0, 1'b1, 1'b0, 0, l0, v, e);
    run_to(e);

    // End bit error
    plan(RSP_R48, 6'd8, 32'h1AA, 1'b1, 1'b1, 4, 2, 2, mk_rsp(6'd8, 32'd7), 1'b1, 1'b1, 0, l0, v, e);
    run_to(e);
    chk("t7_end_bit_err", end_bit_err_o, 1'b1);

    // R48b: DAT0 low for 100 strobes, then high
    b_trans_seen = 1'b0;
    plan(RSP_R48B, 6'd7, 32'h10, 1'b1, 1'b1, 2, 3, 1, mk_rsp(6'd7, 32'd8), 1'b1, 1'b0, 101, l0, v, e);
    run_to(e + 2);
    chk("t8_trans_distance", trans_sn - v, 101);
    chk("t8_complete_after_trans", cmpl_sn, trans_sn + 1);
    chk("t8_short_busy_timeout", b_bto, 1'b1);
    chk("t8_short_no_trans", b_trans_seen, 1'b0);

    // Reset while listening for an R136 response
    plan(RSP_R136, 6'd2, 32'h0, 1'b1, 1'b1, 2, 0, 1, '0, 1'b1, 1'b0, 0, l0, v, e);
    run_to(l0 + 10);
    @(negedge clk_i);
    chk("pre_rst_long", long_rsp_o, 1'b1);
    clk_en_i = 1'b0;
    rst_i = 1'b1;
    #1;
    chk("rst_inhibit", cmd_inhibit_o, 1'b0);
    chk("rst_long", long_rsp_o, 1'b0);
    chk("rst_complete", cmd_complete_o, 1'b0);
    chk("rst_timeout", timeout_err_o, 1'b0);
    clear_from(sn);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    run_to(sn + 8);

    plan(RSP_R48, 6'd17, 32'h2000, 1'b1, 1'b1, 2, 2, 1, mk_rsp(6'd17, 32'd9), 1'b1, 1'b0, 0, l0, v, e);
    run_to(e + 2);
    chk("t10_rsp_literal", rsp_o, 120'hC0FFEE_DEADBEEF_00000011_CAFE0009);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
